// File: rtl/rgb2ycbcr_pipe_if.sv
// Pixel bus between the colour converter and its neighbours: input pixel stream,
// output pixel stream and the valid/ready handshake for each direction.
interface rgb2ycbcr_pipe_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] iR;
  logic [DATA_W-1:0] iG;
  logic [DATA_W-1:0] iB;
  logic              iMode;
  logic              iLast;
  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] oY;
  logic [DATA_W-1:0] oCb;
  logic [DATA_W-1:0] oCr;
  logic              oLast;
  logic              oValid;
  logic              iReady;

  modport slave (
    input  iR, iG, iB, iMode, iLast, iValid, iReady,
    output oReady, oY, oCb, oCr, oLast, oValid
  );

  modport master (
    output iR, iG, iB, iMode, iLast, iValid, iReady,
    input  oReady, oY, oCb, oCr, oLast, oValid
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// Four-stage RGB -> YCbCr (BT.601 full/studio range per pixel) converter with
// valid/ready flow control; the whole pipeline freezes while the output is stalled.
module rgb2ycbcr_pipe #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16
) (
  input logic             iClk,
  input logic             iRstN,
  rgb2ycbcr_pipe_if.slave bus
);

  localparam int ACC_W = DATA_W + 19;
  localparam int FRAC  = 14;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Rows: full range, studio range. Columns: Y(R,G,B), Cb(R,G,B), Cr(R,G,B).
  localparam coef_t COEF [2][9] = '{
    '{coef_t'(4899),  coef_t'(9617),  coef_t'(1868),
      coef_t'(-2765), coef_t'(-5427), coef_t'(8192),
      coef_t'(8192),  coef_t'(-6860), coef_t'(-1332)},
    '{coef_t'(4207),  coef_t'(8260),  coef_t'(1604),
      coef_t'(-2428), coef_t'(-4768), coef_t'(7196),
      coef_t'(7196),  coef_t'(-6026), coef_t'(-1170)}
  };

  // Offsets are pre-shifted into the Q14 accumulator domain: 128*S and 16*S.
  localparam acc_t ROUND        = acc_t'(1) <<< (FRAC - 1);
  localparam acc_t OFF_CHROMA   = acc_t'(1) <<< (DATA_W + 13);
  localparam acc_t OFF_Y_STUDIO = acc_t'(1) <<< (DATA_W + 10);
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  function automatic acc_t mulPix(input logic [DATA_W-1:0] px, input coef_t c);
    acc_t a;
    acc_t k;
    a = $signed({{(ACC_W-DATA_W){1'b0}}, px});
    k = {{(ACC_W-COEF_W){c[COEF_W-1]}}, c};
    return a * k;
  endfunction

  function automatic acc_t offsetFor(input int ch, input logic studio);
    if (ch != 0)  return OFF_CHROMA;
    if (studio)   return OFF_Y_STUDIO;
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] satPix(input acc_t acc);
    acc_t q;
    q = acc >>> FRAC;
    if (q[ACC_W-1])                                     return '0;
    if (q > $signed({{(ACC_W-DATA_W){1'b0}}, PIX_MAX})) return PIX_MAX;
    return q[DATA_W-1:0];
  endfunction

  logic              stall;
  logic              vld_p1, vld_p2, vld_p3;
  logic [DATA_W-1:0] rgb_p1 [3];
  logic              mode_p1, last_p1;
  acc_t              prod_p2 [9];
  logic              mode_p2, last_p2;
  acc_t              sum_p3 [3];
  logic              last_p3;

  assign stall      = bus.oValid & ~bus.iReady;
  assign bus.oReady = ~stall;

  always_ff @(posedge iClk) begin
    if (!stall) begin
      // S1: capture the pixel and its sideband
      rgb_p1[0] <= bus.iR;
      rgb_p1[1] <= bus.iG;
      rgb_p1[2] <= bus.iB;
      mode_p1   <= bus.iMode;
      last_p1   <= bus.iLast;
      // S2: nine products with the pixel's own coefficient set
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < 3; k++) begin
          prod_p2[3*c+k] <= mulPix(rgb_p1[k], COEF[mode_p1][3*c+k]);
        end
      end
      mode_p2 <= mode_p1;
      last_p2 <= last_p1;
      // S3: per-channel sum, offset and rounding constant
      for (int c = 0; c < 3; c++) begin
        sum_p3[c] <= prod_p2[3*c] + prod_p2[3*c+1] + prod_p2[3*c+2]
                     + offsetFor(c, mode_p2) + ROUND;
      end
      last_p3 <= last_p2;
    end
  end

  // S4 (output registers) and the per-stage valid chain
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oY     <= '0;
      bus.oCb    <= '0;
      bus.oCr    <= '0;
      bus.oLast  <= 1'b0;
    end else if (!stall) begin
      vld_p1     <= bus.iValid;
      vld_p2     <= vld_p1;
      vld_p3     <= vld_p2;
      bus.oValid <= vld_p3;
      bus.oY     <= satPix(sum_p3[0]);
      bus.oCb    <= satPix(sum_p3[1]);
      bus.oCr    <= satPix(sum_p3[2]);
      bus.oLast  <= last_p3;
    end
  end

endmodule

// File: doc/rgb2ycbcr_pipe.md
# rgb2ycbcr_pipe

Parametrised, fully pipelined RGB to YCbCr colour-space converter with valid/ready flow control, per-pixel range mode and end-of-line sideband. It supersedes the fixed 8-bit free-running converter in the image-processing chain. It sits between the pixel source (camera/DMA unpacker) and the chroma subsampler, and can stall on downstream backpressure without dropping or duplicating pixels.

## Interface
- DATA_W, 8, component width in bits for both input and output; legal range 8..12.
- iClk  in  1  clock; all state updates on the rising edge.
- iRstN  in  1  asynchronous, active-low reset.
- iR, iG, iB  in  DATA_W each  input components, unsigned.
- iMode  in  1  0 = BT.601 full range (JFIF); 1 = BT.601 studio range. Sampled with each pixel.
- iLast  in  1  end-of-line marker; travels with the pixel.
- iValid  in  1  input pixel valid.
- oReady  out  1  block can accept a pixel this cycle.
- oY, oCb, oCr  out  DATA_W each  output components, unsigned.
- oLast  out  1  iLast of the pixel currently presented.
- oValid  out  1  output pixel valid.
- iReady  in  1  downstream accepts the output this cycle.

## Operation
- Coefficients are signed Q1.14 constants (scale 16384).
- Full range:
  - Y: 4899, 9617, 1868; offset 0.
  - Cb: -2765, -5427, 8192; offset 128·S.
  - Cr: 8192, -6860, -1332; offset 128·S.
- Studio range:
  - Y: 4207, 8260, 1604; offset 16·S.
  - Cb: -2428, -4768, 7196; offset 128·S.
  - Cr: 7196, -6026, -1170; offset 128·S.
- S = 2^(DATA_W-8).
- Each output is computed as: acc = cR·R + cG·G + cB·B + (offset << 14) + 8192.
  - Then result = acc >>> 14, arithmetic shift.
  - Then clamp to [0, 2^DATA_W-1].
- Accumulator width is at least DATA_W+17 bits, signed. Intermediate results never wrap.
- Pipeline has 4 register stages, each with its own valid bit. iMode and iLast ride along with the data.
  - S1: register iR/iG/iB/iMode/iLast.
  - S2: nine products, using coefficients selected by the stage-carried mode.
  - S3: three sums plus offset plus rounding constant.
  - S4: shift, clamp, and the output registers oY/oCb/oCr/oLast/oValid.
- Flow control:
  - Stall = oValid & ~iReady.
  - While stalled, all stages, including valid bits, hold.
  - oReady = ~Stall, combinational.
  - A pixel is accepted on an edge where iValid & oReady.
  - An output is consumed on an edge where oValid & iReady.
- Bubbles (stage valid = 0) advance normally. Bubbles are not collapsed.
- Mode may change on any pixel boundary. Each pixel is converted with its own sampled mode, with no pipeline flush.
- Output data is don't-care while oValid = 0. The bench checks only the registered reset values below.

## Timing
- Reset (iRstN low, asynchronous):
  - All stage valid bits and oValid are 0.
  - oY/oCb/oCr are 0 and oLast is 0.
  - oReady is 1 once oValid = 0.
- Reset asserted mid-stream discards every in-flight pixel. The first pixel after release is accepted on the first edge with iRstN high and iValid high.
- Latency with iReady held high: a pixel accepted at edge n is presented with oValid = 1 after edge n+3. The output stays for exactly 1 cycle if the next pixel follows.
- Throughput is 1 pixel/cycle with iValid and iReady continuously high.
- Stall behaviour:
  - iReady low while oValid = 1 freezes oY/oCb/oCr/oLast/oValid.
  - oReady drops in the same cycle.
  - When iReady returns high, the frozen pixel is consumed on that edge, and the pipeline advances on the same edge.
- iReady low while oValid = 0 does not stall, so bubbles drain.
- iValid low with oReady high inserts a bubble. Inputs in a bubble cycle are ignored.
- No combinational path from iValid to oReady. The only combinational path is iReady and oValid to oReady.

## Test plan
- Full range, DATA_W = 8, continuous stream:
  - White (255,255,255) -> Y=255, Cb=128, Cr=128.
  - Black (0,0,0) -> 0/128/128.
  - Red (255,0,0) -> Y=76, Cb=85, Cr=255 (clamped from 256).
  - Each output appears 3 edges after acceptance.
- Studio range, DATA_W = 8:
  - White -> Y=235, Cb=128, Cr=128.
  - Black -> Y=16, Cb=128, Cr=128.
  - Alternate iMode every pixel on a white stream -> Y sequence 255, 235, 255, 235...
- DATA_W = 10, full range, white (1023,1023,1023) -> Y=1023, Cb=512, Cr=512.
- Backpressure:
  - Stream 64 pixels with random iValid and random iReady (~50%).
  - The output sequence must equal the golden model in order, with no drop and no duplicate.
  - oLast must be set only on pixels 15/31/47/63 matching the input.
  - While iReady is low with oValid high, outputs are stable.
- Reset mid-stream:
  - Assert iRstN low with 3 pixels in flight -> oValid=0 immediately (asynchronous), outputs 0.
  - After release, the first new pixel emerges 3 edges after its acceptance, with no stale pixel.
- Image regression: 64x64 P6 frame pushed through with iReady high -> output bytes match the golden-model file exactly.
